// File: rtl/riscv_pkg.sv
// Shared types for the data-side store buffer: entry payload and word geometry.
package riscv_pkg;

    localparam int unsigned SB_ADDR_W  = 32;
    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic [SB_ADDR_W-3:0] waddr;
        logic [31:0]          data;
        logic [3:0]           mask;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Data-memory bus: posted-write drain channel plus the same-cycle load read port.
interface store_buffer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_raddr;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_wdata, mem_wmask, mem_raddr,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_wdata, mem_wmask, mem_raddr,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/sb_forward_merge.sv
// Per-byte youngest-match select of pending stores over the memory load data.
module sb_forward_merge
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t            entries [DEPTH],
    input  logic [DEPTH-1:0]     valid,
    input  logic [PTR_W-1:0]     head,
    input  logic [SB_ADDR_W-3:0] waddr,
    input  logic [31:0]          mem_rdata,
    output logic [31:0]          read_data
);

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        read_data = mem_rdata;
        idx       = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = head + PTR_W'(k);
            if (valid[idx] && (entries[idx].waddr == waddr)) begin
                for (int b = 0; b < int'(WORD_BYTES); b++) begin
                    if (entries[idx].mask[b]) begin
                        read_data[8*b +: 8] = entries[idx].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and the memory bus, with load forwarding.
module store_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = SB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [31:0]       cpu_write_data,
    input  logic [3:0]        cpu_wmask,
    input  logic              cpu_wen,
    output logic [31:0]       cpu_read_data,
    output logic              cpu_stall,
    output logic              drained,
    store_buffer_if.master    mem
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned EW    = SB_ADDR_W - 2;

    sb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic    full;
    logic    empty;
    logic    push;
    logic    pop;
    logic [EW-1:0] cpu_waddr;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign push      = cpu_wen && !full;
    assign pop       = !empty && mem.mem_ack;
    assign cpu_waddr = EW'(cpu_address[ADDR_W-1:2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                entries[tail] <= '{waddr: cpu_waddr, data: cpu_write_data, mask: cpu_wmask};
                valid[tail]   <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            // Push and pop never share a slot: tail==head only when empty or full.
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign cpu_stall = cpu_wen && full;
    assign drained   = empty;

    assign mem.mem_req   = !empty;
    assign mem.mem_addr  = ADDR_W'({entries[head].waddr, 2'b00});
    assign mem.mem_wdata = entries[head].data;
    assign mem.mem_wmask = entries[head].mask;
    assign mem.mem_raddr = cpu_address;

    sb_forward_merge #(
        .DEPTH (DEPTH)
    ) u_forward_merge (
        .entries   (entries),
        .valid     (valid),
        .head      (head),
        .waddr     (cpu_waddr),
        .mem_rdata (mem.mem_rdata),
        .read_data (cpu_read_data)
    );

endmodule
